// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the parametrised SPI slave:
//   - spi_state_e : frame FSM states
//   - CMD_*       : 2-bit command codes carried in the top bits of a frame
//   - odd_parity  : parity bit that accompanies a word on the wire
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_TX      = 3'd3,
        ST_DONE    = 3'd4
    } spi_state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Parity bit sent alongside a word: 1 when the word holds an odd number
    // of ones. Narrower words are zero-extended by the caller, which leaves
    // the result unchanged.
    function automatic logic odd_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// -----------------------------------------------------------------------------
// spi_slave_param_if
// Bundles the SPI pins and the RAM-side handshake of spi_slave_param.
//   SS_n, MOSI, MISO         : SPI frame select and serial data
//   tx_valid, tx_data        : read data offered by the RAM
//   rx_data, rx_valid        : {cmd, payload} word delivered to the RAM
//   busy, frame_err          : status
// Modports: slave (the SPI slave) and master (the SPI master / RAM side).
// -----------------------------------------------------------------------------
interface spi_slave_param_if #(
    parameter int PAYLOAD_W = 8,
    parameter int TX_W      = 8
);
    logic                   SS_n;
    logic                   MOSI;
    logic                   MISO;
    logic                   tx_valid;
    logic [TX_W-1:0]        tx_data;
    logic [PAYLOAD_W+1:0]   rx_data;
    logic                   rx_valid;
    logic                   busy;
    logic                   frame_err;

    modport slave (
        input  SS_n, MOSI, tx_valid, tx_data,
        output MISO, rx_data, rx_valid, busy, frame_err
    );

    modport master (
        output SS_n, MOSI, tx_valid, tx_data,
        input  MISO, rx_data, rx_valid, busy, frame_err
    );
endinterface

// File: rtl/spi_tx_shifter.sv
// -----------------------------------------------------------------------------
// spi_tx_shifter
// TX_W-bit parallel-in / serial-out shifter driving MISO, MSB first.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force the register (and MISO) to zero; highest priority
//   load       : capture din
//   shift      : shift left by one, filling bit 0 with sin
//   sin        : fill bit (used to walk a trailing parity bit up to the MSB)
//   miso       : register MSB
// -----------------------------------------------------------------------------
module spi_tx_shifter #(
    parameter int TX_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            load,
    input  logic            shift,
    input  logic            sin,
    input  logic [TX_W-1:0] din,
    output logic            miso
);
    logic [TX_W-1:0] sh_r;

    // Shift register: clear > load > shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_r <= {TX_W{1'b0}};
        end else if (clear) begin
            sh_r <= {TX_W{1'b0}};
        end else if (load) begin
            sh_r <= din;
        end else if (shift) begin
            sh_r <= {sh_r[TX_W-2:0], sin};
        end
    end

    assign miso = sh_r[TX_W-1];
endmodule

// File: rtl/spi_slave_param.sv
// -----------------------------------------------------------------------------
// spi_slave_param
// SPI slave for the SPI-to-RAM wrapper. clk is also the SPI bit clock: one
// MOSI bit is sampled per rising edge while SS_n is low. A frame is
// {cmd[1:0], payload[PAYLOAD_W-1:0]}, MSB first. Read data from the RAM is
// shifted out on MISO, MSB first.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : spi_slave_param_if.slave (SS_n, MOSI, MISO, tx_valid,
//                tx_data, rx_data, rx_valid, busy, frame_err)
// Build option: SPI_SLAVE_PARITY_EN adds a parity bit after each received
// frame and after each transmitted word.
// -----------------------------------------------------------------------------
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int PAYLOAD_W = 8,
    parameter int TX_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_slave_param_if.slave   bus
);
    localparam int W = PAYLOAD_W + 2;
`ifdef SPI_SLAVE_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int N       = W + PAR_BITS;
    localparam int TX_N    = TX_W + PAR_BITS;
    localparam int CNT_MAX = (N > TX_N) ? N : TX_N;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    spi_state_e         state_r, next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [N-2:0]       shift_r;
    logic [W-1:0]       rx_data_r;
    logic               rx_valid_r, frame_err_r, busy_r, rd_addr_seen_r;

    logic [N-1:0]       frame_s;
    logic [W-1:0]       word_s;
    logic [1:0]         cmd_s;
    logic               par_ok_s, last_s, tx_fill_s, miso_s;

    logic cnt_load_rx_s, cnt_load_tx_s, cnt_dec_s, rx_sample_s, rx_commit_s;
    logic rx_valid_s, frame_err_s, rd_set_s, rd_clr_s;
    logic tx_load_s, tx_shift_s, tx_clear_s;

    // The bit on MOSI at the final edge completes the frame without
    // first passing through the shift register.
    assign frame_s = {shift_r, bus.MOSI};
    assign word_s  = frame_s[N-1:N-W];
    assign cmd_s   = word_s[W-1:W-2];
    assign last_s  = (cnt_r == CNT_W'(1));

`ifdef SPI_SLAVE_PARITY_EN
    logic tx_par_r;
    assign par_ok_s  = (odd_parity(64'(word_s)) == frame_s[0]);
    // Bit shifted in on the first TX shift reaches the MSB right after the LSB.
    assign tx_fill_s = tx_par_r;

    // Parity of the word being transmitted, captured with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_par_r <= 1'b0;
        end else if (tx_load_s) begin
            tx_par_r <= odd_parity(64'(bus.tx_data));
        end
    end
`else
    assign par_ok_s  = 1'b1;
    assign tx_fill_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; SS_n high always returns to IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!bus.SS_n) next_state_s = ST_RX;
                else           next_state_s = ST_IDLE;
            end
            ST_RX: begin
                if (bus.SS_n)                                  next_state_s = ST_IDLE;
                else if (!last_s)                              next_state_s = ST_RX;
                else if (par_ok_s && (cmd_s == CMD_RD_DATA) && rd_addr_seen_r)
                                                               next_state_s = ST_WAIT_TX;
                else                                           next_state_s = ST_DONE;
            end
            ST_WAIT_TX: begin
                if (bus.SS_n)         next_state_s = ST_IDLE;
                else if (bus.tx_valid) next_state_s = ST_TX;
                else                  next_state_s = ST_WAIT_TX;
            end
            ST_TX: begin
                if (bus.SS_n)   next_state_s = ST_IDLE;
                else if (last_s) next_state_s = ST_DONE;
                else            next_state_s = ST_TX;
            end
            ST_DONE: begin
                if (bus.SS_n) next_state_s = ST_IDLE;
                else          next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: per-edge datapath strobes.
    always_comb begin
        cnt_load_rx_s = 1'b0;
        cnt_load_tx_s = 1'b0;
        cnt_dec_s     = 1'b0;
        rx_sample_s   = 1'b0;
        rx_commit_s   = 1'b0;
        rx_valid_s    = 1'b0;
        frame_err_s   = 1'b0;
        rd_set_s      = 1'b0;
        rd_clr_s      = 1'b0;
        tx_load_s     = 1'b0;
        tx_shift_s    = 1'b0;
        tx_clear_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!bus.SS_n) cnt_load_rx_s = 1'b1;
                else           tx_clear_s    = 1'b1;
            end
            ST_RX: begin
                if (bus.SS_n) begin
                    // Abort wins even on the edge that would take the last bit.
                    frame_err_s = 1'b1;
                    tx_clear_s  = 1'b1;
                end else if (last_s) begin
                    rx_commit_s = par_ok_s;
                    if (!par_ok_s) begin
                        frame_err_s = 1'b1;
                    end else if (cmd_s == CMD_RD_DATA) begin
                        if (rd_addr_seen_r) rx_valid_s  = 1'b1;
                        else                frame_err_s = 1'b1;
                    end else begin
                        rx_valid_s = 1'b1;
                        rd_set_s   = (cmd_s == CMD_RD_ADDR);
                    end
                end else begin
                    rx_sample_s = 1'b1;
                    cnt_dec_s   = 1'b1;
                end
            end
            ST_WAIT_TX: begin
                if (bus.SS_n) begin
                    frame_err_s = 1'b1;
                    tx_clear_s  = 1'b1;
                end else if (bus.tx_valid) begin
                    tx_load_s     = 1'b1;
                    cnt_load_tx_s = 1'b1;
                end else begin
                    tx_clear_s = 1'b1;
                end
            end
            ST_TX: begin
                if (bus.SS_n) begin
                    frame_err_s = 1'b1;
                    tx_clear_s  = 1'b1;
                end else if (last_s) begin
                    tx_clear_s = 1'b1;
                    rd_clr_s   = 1'b1;
                end else begin
                    tx_shift_s = 1'b1;
                    cnt_dec_s  = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.SS_n) tx_clear_s = 1'b1;
                else          tx_clear_s = 1'b1;
            end
            default: tx_clear_s = 1'b1;
        endcase
    end

    // Bit counter and RX shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {(N-1){1'b0}};
        end else begin
            if (cnt_load_rx_s)      cnt_r <= CNT_W'(N);
            else if (cnt_load_tx_s) cnt_r <= CNT_W'(TX_N);
            else if (cnt_dec_s)     cnt_r <= cnt_r - CNT_W'(1);
            if (rx_sample_s) shift_r <= {shift_r[N-3:0], bus.MOSI};
        end
    end

    // Received word and read-address-seen flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data_r      <= {W{1'b0}};
            rd_addr_seen_r <= 1'b0;
        end else begin
            if (rx_commit_s) rx_data_r <= word_s;
            if (rd_set_s)      rd_addr_seen_r <= 1'b1;
            else if (rd_clr_s) rd_addr_seen_r <= 1'b0;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rx_valid_r  <= rx_valid_s;
            frame_err_r <= frame_err_s;
            busy_r      <= (next_state_s != ST_IDLE);
        end
    end

    spi_tx_shifter #(.TX_W(TX_W)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tx_clear_s),
        .load  (tx_load_s),
        .shift (tx_shift_s),
        .sin   (tx_fill_s),
        .din   (bus.tx_data),
        .miso  (miso_s)
    );

    assign bus.MISO      = miso_s;
    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.busy      = busy_r;
    assign bus.frame_err = frame_err_r;
endmodule
